// File: rtl/adder_pkg.sv
// ============================================================================
// Module      : adder_pkg
// Description : Shared FSM state encoding and counter sizing for serial_adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter must hold 0..WIDTH, since it increments on the last RUN cycle too.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module      : full_adder
// Description : Single-bit full adder; the per-bit datapath of serial_adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial LSB-first adder: Sum/Cout = A+B+Cin in WIDTH+1 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int                 CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   sha_q;
    logic [WIDTH-1:0]   shb_q;
    logic [WIDTH-2:0]   psum_q;
    logic [WIDTH-1:0]   psum_d;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               fa_sum;
    logic               fa_cout;

    full_adder u_fa (
        .A    (sha_q[0]),
        .B    (shb_q[0]),
        .Cin  (carry_q),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    // The final sum bit goes straight to Sum, so only WIDTH-1 partial bits are kept.
    assign psum_d = {fa_sum, psum_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sha_q   <= A;
                        shb_q   <= B;
                        carry_q <= Cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    psum_q  <= psum_d[WIDTH-1:1];
                    carry_q <= fa_cout;
                    sha_q   <= sha_q >> 1;
                    shb_q   <= shb_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        sum_q   <= psum_d;
                        cout_q  <= fa_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Sum  = sum_q;
    assign Cout = cout_q;

endmodule

`default_nettype wire
